// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if: bundle of the fetch controller's memory, redirect and
// decode-side signals. The master modport is the fetch controller itself;
// the slave modport is the surrounding environment (memory, execute, decode).
interface if_fetch_ctrl_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          en;
    logic [15:0]   im_pc;
    logic [31:0]   im_instr;
    logic          redirect_valid;
    logic [15:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [15:0]   out_pc;
    logic [CW-1:0] count;
    logic          misalign_err;

    modport master (
        input  en,
        input  im_instr,
        input  redirect_valid,
        input  redirect_pc,
        input  out_ready,
        output im_pc,
        output out_valid,
        output out_instr,
        output out_pc,
        output count,
        output misalign_err
    );

    modport slave (
        output en,
        output im_instr,
        output redirect_valid,
        output redirect_pc,
        output out_ready,
        input  im_pc,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  count,
        input  misalign_err
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch controller. Drives the instruction memory
// address, captures the returned word into a DEPTH-entry prefetch queue and
// hands queued words to decode over valid/ready. Redirects from execute
// flush the queue and reload the fetch address.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- when defined, a redirect
// to a non-word-aligned target locks the fetcher in ERR (sticky misalign_err);
// when undefined, the low two target bits are dropped and fetch continues.
module if_fetch_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_MAX   = 16'h00FC
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_ctrl_if.master bus
);
    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   ONE_C   = CW'(1);
    localparam logic [PW-1:0]   PONE_C  = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [15:0]    fetch_pc_r;
    logic [15:0]    fetch_pc_s;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  count_s;
    logic [PW-1:0]  head_r;
    logic [PW-1:0]  tail_r;
    logic [15:0]    mem_pc_r    [DEPTH];
    logic [31:0]    mem_instr_r [DEPTH];

    logic           redir_s;
    logic [15:0]    redir_pc_s;
    logic           misalign_s;
    logic           push_s;
    logic           pop_s;

`ifdef FETCH_MISALIGN_CHECK_EN
    // Keep the raw target and flag misaligned redirects (ignored once in ERR)
    always_comb begin
        redir_pc_s = bus.redirect_pc;
        if (bus.redirect_valid && (state_r != ST_ERR) && (bus.redirect_pc[1:0] != 2'b00)) begin
            misalign_s = 1'b1;
        end else begin
            misalign_s = 1'b0;
        end
    end

    assign bus.misalign_err = (state_r == ST_ERR);
`else
    logic [1:0] lsb_unused_s;

    // Word-align the redirect target; misalignment is never an error here
    always_comb begin
        redir_pc_s = {bus.redirect_pc[15:2], 2'b00};
        misalign_s = 1'b0;
    end

    assign lsb_unused_s     = bus.redirect_pc[1:0];
    assign bus.misalign_err = 1'b0;
`endif

    // Handshake qualification, next fetch address and next occupancy
    always_comb begin
        redir_s    = 1'b0;
        pop_s      = 1'b0;
        push_s     = 1'b0;
        fetch_pc_s = fetch_pc_r;
        count_s    = count_r;

        if (bus.redirect_valid && (state_r != ST_ERR)) begin
            redir_s = 1'b1;
        end else begin
            redir_s = 1'b0;
        end

        // A redirect kills any same-cycle handshake with decode
        if ((count_r != {CW{1'b0}}) && bus.out_ready && !bus.redirect_valid) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end

        // Pushing into a full queue is only legal alongside a pop
        if ((state_r == ST_RUN) && bus.en && !bus.redirect_valid &&
            ((count_r < DEPTH_C) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end

        if (redir_s) begin
            fetch_pc_s = redir_pc_s;
        end else if (push_s) begin
            if (fetch_pc_r == PC_MAX) begin
                fetch_pc_s = 16'h0000;
            end else begin
                fetch_pc_s = fetch_pc_r + 16'd4;
            end
        end else begin
            fetch_pc_s = fetch_pc_r;
        end

        if (redir_s) begin
            count_s = {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + ONE_C;
                2'b01:   count_s = count_r - ONE_C;
                default: count_s = count_r;
            endcase
        end
    end

    // Next-state decode; ERR only leaves through reset
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (misalign_s) begin
                    state_s = ST_ERR;
                end else if (bus.en) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (misalign_s) begin
                    state_s = ST_ERR;
                end else if (!bus.en) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_ERR:  state_s = ST_ERR;
            default: state_s = ST_IDLE;
        endcase
    end

    // Control registers: FSM state, fetch address, occupancy and pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            count_r    <= {CW{1'b0}};
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            count_r    <= count_s;
            if (redir_s) begin
                head_r <= {PW{1'b0}};
                tail_r <= {PW{1'b0}};
            end else begin
                if (push_s) begin
                    tail_r <= tail_r + PONE_C;
                end else begin
                    tail_r <= tail_r;
                end
                if (pop_s) begin
                    head_r <= head_r + PONE_C;
                end else begin
                    head_r <= head_r;
                end
            end
        end
    end

    // Queue storage: cleared on reset so the head reads as zero afterwards
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_r[i]    <= 16'h0000;
                mem_instr_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            mem_pc_r[tail_r]    <= fetch_pc_r;
            mem_instr_r[tail_r] <= bus.im_instr;
        end else begin
            mem_pc_r[tail_r]    <= mem_pc_r[tail_r];
            mem_instr_r[tail_r] <= mem_instr_r[tail_r];
        end
    end

    assign bus.im_pc     = fetch_pc_r;
    assign bus.count     = count_r;
    assign bus.out_valid = (count_r != {CW{1'b0}});
    assign bus.out_pc    = mem_pc_r[head_r];
    assign bus.out_instr = mem_instr_r[head_r];
endmodule
